pwm_sample_scheduler: RTL
=========================

Name: pwm_sample_scheduler

Overview:
- Sequences the PWM serializer: generates the pwm-step and pwm-symbol timing and buffers incoming duty-cycle samples in a small FIFO.
- Hands one sample to the serializer per symbol period.
- Sits between the host sample source (valid/ready stream) and the shift-register PWM serializer.
- Handles start-up priming, underrun and stop.

Parameters:
- CLKS_PER_STEP, 4: clk cycles per pwm step.
- PWM_STEPS, 64: steps per pwm symbol; maximum duty value.
- SAMPLE_W, 7: sample/duty width; must hold PWM_STEPS.
- FIFO_DEPTH, 8: sample FIFO entries; power of two.
- PRIME_LEVEL, 4: FIFO level required to start or resume.
- IDLE_DUTY, 32: duty loaded during underrun.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run request.
- s_data  in  SAMPLE_W  sample duty value.
- s_valid  in  1  sample valid.
- s_ready  out  1  FIFO can accept a sample.
- duty  out  SAMPLE_W  duty for the next symbol, range 0..PWM_STEPS.
- duty_load  out  1  one-cycle strobe: serializer loads duty.
- step_tick  out  1  one-cycle strobe per pwm step; serializer shifts on it.
- running  out  1  state is RUN or UNDERRUN.
- underrun  out  1  sticky underrun flag.
- underrun_clr  in  1  clears underrun.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; FIFO emptied. All outputs are 0: duty, duty_load, step_tick, running, underrun, fifo_level, s_ready.
- s_ready is registered. It equals !full, is 0 during rst, and does not depend on a same-cycle pop. A push occurs when s_valid && s_ready.
- Step counter runs 0..CLKS_PER_STEP-1 only in RUN/UNDERRUN; it is held at 0 otherwise.
- step_tick=1 when step count == CLKS_PER_STEP-1.
- Symbol counter increments on step_tick and wraps at PWM_STEPS-1.
- sym_tick (internal) = step_tick && symbol count == PWM_STEPS-1. Symbol period = CLKS_PER_STEP*PWM_STEPS clk cycles.
- FSM states: IDLE, PRIME, RUN, UNDERRUN.
  - IDLE: enable=1 -> PRIME.
  - PRIME: enable=0 -> IDLE. Otherwise, when fifo_level >= PRIME_LEVEL: pop, duty<=head, duty_load=1 on the next cycle, counters start from 0, go to RUN.
  - RUN, on sym_tick: if FIFO non-empty, pop, duty<=head, pulse duty_load. If empty, duty<=IDLE_DUTY, pulse duty_load, set underrun, go to UNDERRUN.
  - UNDERRUN, on sym_tick: if fifo_level >= PRIME_LEVEL, pop and load as in RUN, go to RUN. Otherwise reload IDLE_DUTY and pulse duty_load.
- Leaving operation: enable=0 in RUN/UNDERRUN -> IDLE at the next edge. Counters clear, duty<=0, duty_load pulses once to zero the serializer, FIFO is flushed.
- Latency: a pop at edge N gives duty/duty_load valid in cycle N+1. duty_load is coincident with the first step_tick period of the new symbol.
- Clamp: a popped value > PWM_STEPS is loaded as PWM_STEPS.
- Simultaneous push and pop:
  - Empty FIFO: no bypass; the pop sees empty, so the underrun path is taken; the push is stored.
  - Full FIFO: the push is refused (s_ready=0); the pop proceeds.
- underrun is set on each underrun event. It clears on underrun_clr=1 unless a set occurs in the same cycle; set wins.
- fifo_level updates one cycle after push/pop; simultaneous push+pop leaves it unchanged.

Optional Feature:
- Macro: PWM_SCHED_TEST_TONE_EN.
- Defined: adds input test_tone (1 bit). When test_tone=1 in PRIME/RUN/UNDERRUN:
  - samples come from an internal 100-entry sine ROM (values 0..PWM_STEPS, midscale 32); index advances per symbol and wraps 99->0.
  - PRIME proceeds without waiting for PRIME_LEVEL; underrun never occurs; the FIFO still accepts data but is not popped.
- Undefined: no test_tone port and no ROM; samples come only from the FIFO.

Decomposition:
- pwm_sched_pkg: FSM state encoding, default parameter constants, sine ROM contents.
- Sub-module sched_fifo: synchronous FIFO with registered full/empty/level.
- Step/symbol ticks use two instances of the existing counter module.

Test Plan:
- Reset then enable=1 with no data: stays in PRIME, running=0, step_tick never asserts, duty=0.
- Push 4 samples (10,20,30,40): at the PRIME_LEVEL crossing, duty=10 with a duty_load pulse; then duty=20,30,40 at 256-cycle intervals.
- After the 4 samples with no further data: at the next symbol, duty=32, underrun=1, state UNDERRUN. Push 4 samples: the next symbol loads the first of them and returns to RUN. underrun_clr then clears the flag.
- Fill 8 samples while in PRIME (level crosses 4 and starts RUN), keep s_valid high: s_ready=0 at level 8; no sample is lost or duplicated, checked by scoreboard.
- Push 100 and 64: duty loads 64 then 64 (clamp); deassert enable mid-symbol: next cycle duty=0, duty_load=1, running=0, fifo_level=0.
- PWM_SCHED_TEST_TONE_EN with test_tone=1: duty follows the ROM sequence, wraps after 100 symbols, underrun stays 0.

Source files
------------

// File: rtl/pwm_sched_pkg.sv
// Shared definitions for the PWM sample scheduler: FSM state codes,
// default parameter values and the test-tone sine table.
// The sine table is only referenced when PWM_SCHED_TEST_TONE_EN is defined.
package pwm_sched_pkg;

    // Default configuration
    localparam int unsigned CLKS_PER_STEP_DEF = 4;
    localparam int unsigned PWM_STEPS_DEF     = 64;
    localparam int unsigned SAMPLE_W_DEF      = 7;
    localparam int unsigned FIFO_DEPTH_DEF    = 8;
    localparam int unsigned PRIME_LEVEL_DEF   = 4;
    localparam int unsigned IDLE_DUTY_DEF     = 32;

    // Test-tone table length (one entry per symbol)
    localparam int unsigned SINE_LEN = 100;

    // Scheduler FSM encoding (kept as plain constants for legacy compatibility)
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRIME    = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_UNDERRUN = 2'd3;

    // First quadrant of round(32*sin(2*pi*k/100)), k = 0..25
    function automatic logic [5:0] sine_quarter(input int unsigned k);
        case (k)
            0:  return 6'd0;
            1:  return 6'd2;
            2:  return 6'd4;
            3:  return 6'd6;
            4:  return 6'd8;
            5:  return 6'd10;
            6:  return 6'd12;
            7:  return 6'd14;
            8:  return 6'd15;
            9:  return 6'd17;
            10: return 6'd19;
            11: return 6'd20;
            12: return 6'd22;
            13: return 6'd23;
            14: return 6'd25;
            15: return 6'd26;
            16: return 6'd27;
            17: return 6'd28;
            18: return 6'd29;
            19: return 6'd30;
            20: return 6'd30;
            21: return 6'd31;
            22: return 6'd31;
            23: return 6'd32;
            24: return 6'd32;
            25: return 6'd32;
            default: return 6'd0;
        endcase
    endfunction

    // Full 100-entry sine ROM around midscale 32, range 0..64,
    // folded from the first quadrant.
    function automatic logic [6:0] sine_rom(input int unsigned idx);
        int v;
        if (idx <= 25)
            v = 32 + int'(sine_quarter(idx));
        else if (idx <= 50)
            v = 32 + int'(sine_quarter(50 - idx));
        else if (idx <= 75)
            v = 32 - int'(sine_quarter(idx - 50));
        else if (idx < SINE_LEN)
            v = 32 - int'(sine_quarter(SINE_LEN - idx));
        else
            v = 32;
        return 7'(v);
    endfunction

endpackage

// File: rtl/sched_counter.sv
// Modulo-MAX event counter used for the pwm step and symbol timebases.
// at_max flags the last count so the caller can derive its tick.
module sched_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;

    logic [W-1:0] count;

    assign at_max = (count == W'(MAX - 1));

    // Count inc events, wrapping after MAX-1; clr holds the count at zero
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc)
            count <= at_max ? '0 : count + W'(1);
    end

endmodule

// File: rtl/sched_fifo.sv
// Synchronous sample FIFO with registered ready/empty/level.
// wr_ready is a registered !full and ignores a same-cycle read; flush
// empties the FIFO and drops any write in the same cycle.
module sched_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [W-1:0]                 wr_data,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic                         rd_en,
    output logic [W-1:0]                 rd_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [LW-1:0] level_n;

    assign push    = wr_valid && wr_ready && !flush;
    assign pop     = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Occupancy after this cycle's push/pop/flush
    always_comb begin
        level_n = level;
        if (flush)
            level_n = '0;
        else if (push && !pop)
            level_n = level + LW'(1);
        else if (pop && !push)
            level_n = level - LW'(1);
    end

    // Sample storage
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            wr_ready <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
            level    <= level_n;
            empty    <= (level_n == '0);
            wr_ready <= (level_n != LW'(DEPTH));
        end
    end

endmodule

// File: rtl/pwm_sample_scheduler.sv
// PWM sample scheduler: generates pwm step/symbol timing, buffers host
// duty samples and hands one duty value to the serializer per symbol.
// Optional build macro PWM_SCHED_TEST_TONE_EN adds a test_tone input that
// substitutes an internal 100-entry sine sequence for FIFO data.
module pwm_sample_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int unsigned CLKS_PER_STEP = CLKS_PER_STEP_DEF,
    parameter int unsigned PWM_STEPS     = PWM_STEPS_DEF,
    parameter int unsigned SAMPLE_W      = SAMPLE_W_DEF,
    parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int unsigned PRIME_LEVEL   = PRIME_LEVEL_DEF,
    parameter int unsigned IDLE_DUTY     = IDLE_DUTY_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
`ifdef PWM_SCHED_TEST_TONE_EN
    input  logic                              test_tone,
`endif
    input  logic [SAMPLE_W-1:0]               s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [SAMPLE_W-1:0]               duty,
    output logic                              duty_load,
    output logic                              step_tick,
    output logic                              running,
    output logic                              underrun,
    input  logic                              underrun_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]          state;
    logic [1:0]          state_n;
    logic                run_st;
    logic                cnt_clr;
    logic                step_at_max;
    logic                sym_at_max;
    logic                sym_tick;
    logic                prime_ok;
    logic                pop;
    logic                load;
    logic [SAMPLE_W-1:0] load_val;
    logic                flush;
    logic                ur_set;
    logic [SAMPLE_W-1:0] fifo_head;
    logic                fifo_empty;
    logic                tone_on;
    logic [SAMPLE_W-1:0] tone_duty;

    function automatic logic [SAMPLE_W-1:0] clamp_duty(input logic [SAMPLE_W-1:0] v);
        return (v > SAMPLE_W'(PWM_STEPS)) ? SAMPLE_W'(PWM_STEPS) : v;
    endfunction

    assign run_st    = (state == ST_RUN) || (state == ST_UNDERRUN);
    assign running   = run_st;
    assign cnt_clr   = !run_st || !enable;
    assign step_tick = run_st && step_at_max;
    assign sym_tick  = step_tick && sym_at_max;
    assign prime_ok  = (fifo_level >= LW'(PRIME_LEVEL));

    sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_data  (s_data),
        .wr_valid (s_valid),
        .wr_ready (s_ready),
        .rd_en    (pop),
        .rd_data  (fifo_head),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    sched_counter #(
        .MAX (CLKS_PER_STEP)
    ) u_step_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (run_st),
        .at_max (step_at_max)
    );

    sched_counter #(
        .MAX (PWM_STEPS)
    ) u_sym_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (step_tick),
        .at_max (sym_at_max)
    );

`ifdef PWM_SCHED_TEST_TONE_EN
    logic [6:0] tone_idx;

    assign tone_on   = test_tone;
    assign tone_duty = SAMPLE_W'(sine_rom(32'(tone_idx)));

    // Every non-stop load while the tone is on consumes one ROM entry
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE)
            tone_idx <= '0;
        else if (load && tone_on && state_n != ST_IDLE)
            tone_idx <= (tone_idx == 7'(SINE_LEN - 1)) ? '0 : tone_idx + 7'd1;
    end
`else
    assign tone_on   = 1'b0;
    assign tone_duty = '0;
`endif

    // Next state, FIFO pop and duty selection
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        flush    = 1'b0;
        ur_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable)
                    state_n = ST_PRIME;
            end
            ST_PRIME: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                end else if (tone_on) begin
                    load     = 1'b1;
                    load_val = tone_duty;
                    state_n  = ST_RUN;
                end else if (prime_ok) begin
                    pop      = 1'b1;
                    load     = 1'b1;
                    load_val = clamp_duty(fifo_head);
                    state_n  = ST_RUN;
                end
            end
            ST_RUN, ST_UNDERRUN: begin
                if (!enable) begin
                    // Stop: zero the serializer once and drop buffered data
                    state_n  = ST_IDLE;
                    load     = 1'b1;
                    load_val = '0;
                    flush    = 1'b1;
                end else if (sym_tick) begin
                    if (tone_on) begin
                        load     = 1'b1;
                        load_val = tone_duty;
                        state_n  = ST_RUN;
                    end else if ((state == ST_RUN) ? !fifo_empty : prime_ok) begin
                        pop      = 1'b1;
                        load     = 1'b1;
                        load_val = clamp_duty(fifo_head);
                        state_n  = ST_RUN;
                    end else begin
                        load     = 1'b1;
                        load_val = SAMPLE_W'(IDLE_DUTY);
                        ur_set   = 1'b1;
                        state_n  = ST_UNDERRUN;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, duty register, load strobe and sticky underrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            duty      <= '0;
            duty_load <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            duty_load <= load;
            if (load)
                duty <= load_val;
            underrun  <= ur_set || (underrun && !underrun_clr);
        end
    end

endmodule
